// File: rtl/minbd_redirect.sv
// Side-buffer / redirection stage ahead of the MinBD silver-flit selector.
// Latency: 1 cycle from port inputs (and buffer state) to nad/sad/ead/wad.
// Backpressure: defl_ready drops when the buffer is full or a forced swap is in progress.
//
// Optional feature macro: MINBD_REDIRECT_SWAP_EN
//   defined     -> starvation counter, rotating victim pointer and forced head/network swap
//   not defined -> buffer head waits indefinitely for an empty port slot
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   northad/southad/eastad/westad port flits {valid, silver, rsvd[2:0], dest[5:0]}
//   defl_flit/defl_valid/defl_ready  deflected flit offered to the side buffer
//   nad/sad/ead/wad               registered port flits to the silver-flit stage
//   sb_count/sb_full/sb_empty     registered side-buffer occupancy
module minbd_redirect #(
   parameter int SB_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [10:0]                 northad,
   input  logic [10:0]                 southad,
   input  logic [10:0]                 eastad,
   input  logic [10:0]                 westad,
   input  logic [10:0]                 defl_flit,
   input  logic                        defl_valid,
   output logic                        defl_ready,
   output logic [10:0]                 nad,
   output logic [10:0]                 sad,
   output logic [10:0]                 ead,
   output logic [10:0]                 wad,
   output logic [$clog2(SB_DEPTH):0]   sb_count,
   output logic                        sb_full,
   output logic                        sb_empty
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SB_DEPTH);

   // Port slot indices; N has the highest reinjection priority.
   localparam logic [1:0] PORT_N = 2'd0;
   localparam logic [1:0] PORT_S = 2'd1;
   localparam logic [1:0] PORT_E = 2'd2;
   localparam logic [1:0] PORT_W = 2'd3;

   // Buffered flits are always marked valid and never silver: silver status
   // is re-decided downstream once the flit is back in the network.
   function automatic logic [10:0] to_buffer(input logic [10:0] f);
      to_buffer = (f & 11'h1FF) | 11'h400;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [10:0]       sb_mem_q [SB_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic [3:0][10:0]  port_q, port_d;

`ifdef MINBD_REDIRECT_SWAP_EN
   localparam logic [7:0] STARVE_C = 8'(STARVE_LIMIT);
   logic [7:0]        starve_q, starve_d;
   logic [1:0]        victim_q, victim_d;
   logic [10:0]       victim_flit;
`endif

   // ------------------------------------------------------------------
   // Slot decode
   // ------------------------------------------------------------------
   logic [3:0][10:0]  port_in;
   logic [3:0]        slot_free;
   logic [1:0]        free_idx;
   logic              all_valid;
   logic [10:0]       head_flit;

   assign port_in   = {westad, eastad, southad, northad};
   assign head_flit = sb_mem_q[head_q];
   assign all_valid = ~|slot_free;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         slot_free[i] = ~port_in[i][10];
      end
   end

   // First empty slot in N, S, E, W order; only meaningful when one exists.
   always_comb begin
      free_idx = PORT_W;
      if (slot_free[0]) begin
         free_idx = PORT_N;
      end else if (slot_free[1]) begin
         free_idx = PORT_S;
      end else if (slot_free[2]) begin
         free_idx = PORT_E;
      end
   end

   // ------------------------------------------------------------------
   // Reinjection / swap decisions
   // ------------------------------------------------------------------
   logic reinject;
   logic swap_now;
   logic do_swap;
   logic push_defl;
   logic wr_en;
   logic pop;
   logic [10:0] wr_dat;

   assign reinject = !empty_q && (|slot_free);

`ifdef MINBD_REDIRECT_SWAP_EN
   // swap_now is purely registered so defl_ready has no path from the ports.
   // If a slot happens to free up in the swap cycle, the ordinary
   // reinjection is taken instead; the counter then clears either way.
   assign swap_now    = (starve_q == STARVE_C);
   assign do_swap     = swap_now && !reinject;
   assign victim_flit = port_in[victim_q];
`else
   assign swap_now = 1'b0;
   assign do_swap  = 1'b0;
`endif

   assign defl_ready = !full_q && !swap_now;
   assign push_defl  = defl_valid && defl_ready;
   // A swap pushes the displaced network flit; it never overlaps a capture
   // because defl_ready is low whenever a swap can happen.
   assign wr_en      = push_defl || do_swap;
   assign pop        = reinject || do_swap;

   always_comb begin
      wr_dat = to_buffer(defl_flit);
`ifdef MINBD_REDIRECT_SWAP_EN
      if (do_swap) begin
         wr_dat = to_buffer(victim_flit);
      end
`endif
   end

   // ------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         // Invalid slots are normalised to all-zero; valid ones pass untouched.
         port_d[i] = port_in[i][10] ? port_in[i] : 11'h000;
      end
      if (reinject) begin
         port_d[free_idx] = head_flit;
      end
`ifdef MINBD_REDIRECT_SWAP_EN
      if (do_swap) begin
         port_d[victim_q] = head_flit;
      end
`endif
   end

   always_comb begin
      head_d  = pop   ? head_q + PTR_W'(1) : head_q;
      tail_d  = wr_en ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

`ifdef MINBD_REDIRECT_SWAP_EN
   always_comb begin
      if (reinject || empty_q || do_swap) begin
         starve_d = 8'd0;
      end else if (all_valid) begin
         starve_d = starve_q + 8'd1;
      end else begin
         starve_d = starve_q;
      end
      victim_d = do_swap ? victim_q + 2'd1 : victim_q;
   end
`endif

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         port_q   <= '0;
`ifdef MINBD_REDIRECT_SWAP_EN
         starve_q <= 8'd0;
         victim_q <= PORT_N;
`endif
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         port_q   <= port_d;
`ifdef MINBD_REDIRECT_SWAP_EN
         starve_q <= starve_d;
         victim_q <= victim_d;
`endif
      end
   end

   // Storage needs no reset: the pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         sb_mem_q[tail_q] <= wr_dat;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign nad      = port_q[0];
   assign sad      = port_q[1];
   assign ead      = port_q[2];
   assign wad      = port_q[3];
   assign sb_count = count_q;
   assign sb_full  = full_q;
   assign sb_empty = empty_q;

endmodule

// File: tb/tb_minbd_redirect.sv
// Self-checking bench for minbd_redirect: directed steps push the expected
// port outputs into a scoreboard queue; a monitor pops and compares them
// one cycle later. Occupancy/ready flags are checked inline.
module tb_minbd_redirect;

   localparam int SB_DEPTH     = 4;
   localparam int STARVE_LIMIT = 8;

   localparam logic [10:0] Z   = 11'h000;
   localparam logic [10:0] PN  = 11'h401;
   localparam logic [10:0] PS  = 11'h402;
   localparam logic [10:0] PE  = 11'h403;
   localparam logic [10:0] PWF = 11'h404;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] northad, southad, eastad, westad;
   logic [10:0] defl_flit;
   logic        defl_valid;
   logic        defl_ready;
   logic [10:0] nad, sad, ead, wad;
   logic [2:0]  sb_count;
   logic        sb_full, sb_empty;

   always #5 clk = ~clk;

   minbd_redirect #(
      .SB_DEPTH     (SB_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .northad    (northad),
      .southad    (southad),
      .eastad     (eastad),
      .westad     (westad),
      .defl_flit  (defl_flit),
      .defl_valid (defl_valid),
      .defl_ready (defl_ready),
      .nad        (nad),
      .sad        (sad),
      .ead        (ead),
      .wad        (wad),
      .sb_count   (sb_count),
      .sb_full    (sb_full),
      .sb_empty   (sb_empty)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [43:0] ports;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [43:0] pk(input logic [10:0] n, input logic [10:0] s,
                                      input logic [10:0] e, input logic [10:0] w);
      return {n, s, e, w};
   endfunction

   // Scoreboard consumer: every driven cycle has exactly one expected entry.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check_eq(mon_e.tag, 64'({nad, sad, ead, wad}), 64'(mon_e.ports));
      end
   end

   // Drive one cycle of stimulus and record what the ports must show after it.
   task automatic step(input logic r,
                       input logic [10:0] n, input logic [10:0] s,
                       input logic [10:0] e, input logic [10:0] w,
                       input logic dv, input logic [10:0] df,
                       input logic [43:0] exp, input string tag);
      exp_t x;
      @(negedge clk);
      rst        = r;
      northad    = n;
      southad    = s;
      eastad     = e;
      westad     = w;
      defl_valid = dv;
      defl_flit  = df;
      x.tag      = tag;
      x.ports    = exp;
      sb_q.push_back(x);
      @(posedge clk);
      #2;
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic full,
                            input logic empty, input logic rdy);
      check_eq({tag, "_cnt"},   64'(sb_count),   64'(cnt));
      check_eq({tag, "_full"},  64'(sb_full),    64'(full));
      check_eq({tag, "_empty"}, 64'(sb_empty),   64'(empty));
      check_eq({tag, "_rdy"},   64'(defl_ready), 64'(rdy));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0]  df;
      logic [43:0]  pass;
      pass = pk(PN, PS, PE, PWF);

      rst        = 1'b1;
      northad    = Z;
      southad    = Z;
      eastad     = Z;
      westad     = Z;
      defl_flit  = Z;
      defl_valid = 1'b0;

      // Reset and idle
      step(1'b1, Z, Z, Z, Z, 1'b0, Z, '0, "rst_a");
      step(1'b1, Z, Z, Z, Z, 1'b0, Z, '0, "rst_b");
      chk_state("rst", 0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, Z, Z, Z, Z, 1'b0, Z, '0, "idle");
         chk_state("idle", 0, 1'b0, 1'b1, 1'b1);
      end

      // Capture with all ports empty, then reinjection into N
      step(1'b0, Z, Z, Z, Z, 1'b1, 11'h405, '0, "cap_push");
      chk_state("cap1", 1, 1'b0, 1'b0, 1'b1);
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(11'h405, Z, Z, Z), "cap_reinj");
      chk_state("cap2", 0, 1'b0, 1'b1, 1'b1);

      // Fill while blocked; silver bit is cleared and valid forced on capture
      for (int i = 0; i < 4; i++) begin
         df = (i == 3) ? 11'h213 : 11'(11'h610 + i);
         step(1'b0, PN, PS, PE, PWF, 1'b1, df, pass, "fill");
      end
      chk_state("full", 4, 1'b1, 1'b0, 1'b0);
      step(1'b0, PN, PS, PE, PWF, 1'b1, 11'h7AA, pass, "fill5");
      chk_state("full5", 4, 1'b1, 1'b0, 1'b0);

      // Drain: capture refused while full even with a pop; then pop+push
      step(1'b0, Z, Z, Z, Z, 1'b1, 11'h455, pk(11'h410, Z, Z, Z), "drn1");
      chk_state("drn1", 3, 1'b0, 1'b0, 1'b1);
      step(1'b0, Z, Z, Z, Z, 1'b1, 11'h466, pk(11'h411, Z, Z, Z), "drn2");
      chk_state("drn2", 3, 1'b0, 1'b0, 1'b1);
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(11'h412, Z, Z, Z), "drn3");
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(11'h413, Z, Z, Z), "drn4");
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(11'h466, Z, Z, Z), "drn5");
      chk_state("drn5", 0, 1'b0, 1'b1, 1'b1);

      // Reinjection priority and single reinjection per cycle
      step(1'b0, PN, PS, PE, PWF, 1'b1, 11'h411, pass, "ld411");
      chk_state("ld411", 1, 1'b0, 1'b0, 1'b1);
      step(1'b0, PN, Z, PE, PWF, 1'b0, Z, pk(PN, 11'h411, PE, PWF), "reinj_s");
      chk_state("reinj_s", 0, 1'b0, 1'b1, 1'b1);
      step(1'b0, PN, PS, PE, PWF, 1'b1, 11'h421, pass, "ld421");
      step(1'b0, PN, PS, PE, PWF, 1'b1, 11'h422, pass, "ld422");
      chk_state("ld422", 2, 1'b0, 1'b0, 1'b1);
      step(1'b0, PN, PS, Z, Z, 1'b0, Z, pk(PN, PS, 11'h421, Z), "reinj_e");
      chk_state("reinj_e", 1, 1'b0, 1'b0, 1'b1);
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(11'h422, Z, Z, Z), "reinj_n");
      chk_state("reinj_n", 0, 1'b0, 1'b1, 1'b1);

      // Pass-through keeps silver bit; invalid slot with junk becomes zero
      step(1'b0, 11'h6C1, Z, 11'h7FF, 11'h0FF, 1'b0, Z, pk(11'h6C1, Z, 11'h7FF, Z), "pass_silver");

`ifdef MINBD_REDIRECT_SWAP_EN
      // Forced swap on the 9th blocked cycle, victim N then S
      step(1'b0, 11'h601, PS, PE, PWF, 1'b1, 11'h422, pk(11'h601, PS, PE, PWF), "sw_load");
      for (int i = 0; i < STARVE_LIMIT; i++) begin
         step(1'b0, 11'h601, PS, PE, PWF, 1'b0, Z, pk(11'h601, PS, PE, PWF), "sw_blk");
      end
      chk_state("sw_pre", 1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 11'h601, PS, PE, PWF, 1'b1, 11'h7AA, pk(11'h422, PS, PE, PWF), "sw_swap1");
      chk_state("sw_post", 1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < STARVE_LIMIT; i++) begin
         step(1'b0, 11'h601, PS, PE, PWF, 1'b0, Z, pk(11'h601, PS, PE, PWF), "sw_blk2");
      end
      step(1'b0, 11'h601, PS, PE, PWF, 1'b0, Z, pk(11'h601, 11'h401, PE, PWF), "sw_swap2");
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(11'h402, Z, Z, Z), "sw_drain");
      chk_state("sw_drain", 0, 1'b0, 1'b1, 1'b1);
`endif

      // Reset in the middle of a (would-be) swap with three entries held
      for (int i = 0; i < 3; i++) begin
         step(1'b0, PN, PS, PE, PWF, 1'b1, 11'(11'h430 + i), pass, "rs_load");
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, PN, PS, PE, PWF, 1'b0, Z, pass, "rs_blk");
      end
      check_eq("rs_pre_cnt", 64'(sb_count), 64'(3));
      step(1'b1, PN, PS, PE, PWF, 1'b0, Z, '0, "rs_rst");
      chk_state("rs_rst", 0, 1'b0, 1'b1, 1'b1);

      // Old contents discarded: a fresh capture comes straight back out
      step(1'b0, Z, Z, Z, Z, 1'b1, 11'h455, '0, "rs_cap");
      chk_state("rs_cap", 1, 1'b0, 1'b0, 1'b1);
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(11'h455, Z, Z, Z), "rs_reinj");
      chk_state("rs_reinj", 0, 1'b0, 1'b1, 1'b1);

`ifdef MINBD_REDIRECT_SWAP_EN
      // Victim pointer back at N after reset
      step(1'b0, PN, PS, PE, PWF, 1'b1, 11'h444, pass, "rv_load");
      for (int i = 0; i < STARVE_LIMIT; i++) begin
         step(1'b0, PN, PS, PE, PWF, 1'b0, Z, pass, "rv_blk");
      end
      step(1'b0, PN, PS, PE, PWF, 1'b0, Z, pk(11'h444, PS, PE, PWF), "rv_swap");
      step(1'b0, Z, Z, Z, Z, 1'b0, Z, pk(PN, Z, Z, Z), "rv_drain");
      chk_state("rv_drain", 0, 1'b0, 1'b1, 1'b1);
`endif

      @(negedge clk);
      check_eq("sb_queue_drained", 64'(sb_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/minbd_redirect.md
# minbd_redirect

Side-buffer and redirection stage of the MinBD router pipeline, sitting directly upstream of the silver-flit selection stage. Takes the four port flits leaving injection, reinjects flits previously parked in a small side buffer into empty slots, and, on sustained starvation, swaps the buffer head with a network flit. Deflected flits returned from the permutation network are captured into the side buffer. All four port outputs are registered and feed the silver-flit stage one cycle later.

## Interface
- SB_DEPTH, 4: side-buffer entries (power of two, 2..16).
- STARVE_LIMIT, 8: consecutive blocked cycles before a forced swap (1..255).
- clk  in  1  rising-edge clock; one clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- northad, southad, eastad, westad  in  11 each  port flits: [10] valid, [9] silver, [8:6] reserved (passed through), [5:0] destination.
- defl_flit  in  11  deflected flit offered for buffering.
- defl_valid  in  1  defl_flit is valid this cycle.
- defl_ready  out  1  buffer accepts defl_flit this cycle (combinational).
- nad, sad, ead, wad  out  11 each  registered port flits to the silver-flit stage.
- sb_count  out  $clog2(SB_DEPTH)+1  current buffer occupancy.
- sb_full, sb_empty  out  1  occupancy flags.

## Operation
- Slot empty ⇔ flit bit [10] = 0; empty input slots pass through as 11'b0.
- Side buffer: circular FIFO, SB_DEPTH×11, head/tail pointers wrap modulo SB_DEPTH.
- Capture: push defl_flit when defl_valid && defl_ready; stored with bit [9] cleared, bit [10] forced 1.
- defl_ready = (sb_count < SB_DEPTH) && !swap_now; sender retries (keeps deflecting) when low; dropped flits are not the block's concern.
- Reinject: if buffer non-empty and any input slot empty, head flit is placed in the first empty slot in fixed priority N, S, E, W; head popped. At most one reinjection per cycle.
- Starvation counter: increments when buffer non-empty and all four slots valid; clears on any reinjection, when buffer empty, and after a swap.
- swap_now = (starve_cnt == STARVE_LIMIT): head flit replaces the flit on the victim port; that network flit is written to the buffer tail (bit [9] cleared); count unchanged. Victim pointer then rotates N→S→E→W→N.
- Pop and capture in the same cycle are allowed (count unchanged); capture when full is refused even if a pop occurs that cycle.
- Non-selected slots pass through unchanged, including bit [9].

## Timing
- Output latency: 1 cycle; nad/sad/ead/wad at edge k+1 reflect inputs and buffer state at edge k.
- sb_count/sb_full/sb_empty registered, updated at the same edge as the push/pop.
- defl_ready combinational from registered state only (no path from port inputs).
- Reset (rst=1 at an edge): nad=sad=ead=wad=0, sb_count=0, sb_empty=1, sb_full=0, starve_cnt=0, victim=N, pointers=0; buffer contents discarded, including mid-swap.
- Swap occurs in the cycle starve_cnt reaches STARVE_LIMIT, i.e. STARVE_LIMIT+1 blocked cycles after the buffer first becomes blocked.

## Configuration
- MINBD_REDIRECT_SWAP_EN defined: starvation counter, victim pointer and forced swap present as above.
- Not defined: no counter, no swap; buffer head waits indefinitely for an empty slot; defl_ready = (sb_count < SB_DEPTH).

## Test plan
- Reset then idle: all outputs 0, sb_empty=1, defl_ready=1 for 3 cycles after rst deasserts.
- Capture 11'h405 with all ports empty: next cycle sb_count=1; following cycle nad=11'h405, sb_count=0.
- Fill 4 entries, offer 5th with defl_valid: defl_ready=0, sb_full=1, sb_count stays 4.
- Buffer holds 11'h411, N valid 11'h401, S empty: sad=11'h411, nad=11'h401 next cycle.
- Swap enabled, STARVE_LIMIT=8, buffer 11'h422, all ports valid with N=11'h601: on 9th blocked cycle nad=11'h422, buffer holds 11'h401 (silver cleared); next swap targets S.
- Assert rst mid-swap with sb_count=3: next cycle sb_count=0, outputs 0, victim=N.
